// File: rtl/binary_ram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// binary_ram_ctrl_pkg
// Shared definitions for the SR-latch binary-cell RAM controller and any
// array-side logic that needs the same encodings.
//   state_t      : controller FSM state encoding (3 bits)
//   MEM_RD/MEM_WR: values of the shared rd_wr line (1 = read, 0 = write)
//   DEF_*        : default geometry and access length
// -----------------------------------------------------------------------------
package binary_ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_ACC_CYC = 2;

    // Width of the access-length down-counter; bounds ACC_CYC to 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/binary_ram_ctrl_dec.sv
// -----------------------------------------------------------------------------
// addr_onehot_dec
// Binary word address to one-hot word select, with an enable that forces all
// selects low. Usable both by the controller and by array-side decode.
//   en     in  1              : 0 forces onehot to all zeros
//   addr   in  ADDR_W         : word address
//   onehot out 2**ADDR_W      : bit i high selects word i
// -----------------------------------------------------------------------------
module addr_onehot_dec
    import binary_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(2**ADDR_W)-1:0]   onehot
);

    // Exactly one bit set when enabled, none otherwise.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/binary_ram_ctrl.sv
// -----------------------------------------------------------------------------
// binary_ram_ctrl
// Initiator-side controller for a word-organised RAM of SR-latch cells.
// Takes one read/write request at a time over valid/ready, drives the memory
// strobes as setup / access pulse / hold so the latches never see a spurious
// write, then returns a one-cycle response.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_we/addr/wdata    : request type, word address, write data
//   rsp_valid            : one-cycle response pulse, no backpressure
//   rsp_we/rsp_rdata     : echoed type, read data (0 for writes)
//   mem_cs               : one-hot word select
//   mem_rd_wr            : shared rd/wr line, 1 = read
//   mem_wr_data          : shared write bit-lines
//   mem_rd_data          : OR of all cells' gated read data
// -----------------------------------------------------------------------------
module binary_ram_ctrl
    import binary_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_CYC = DEF_ACC_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_we,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [(2**ADDR_W)-1:0]  mem_cs,
    output logic                    mem_rd_wr,
    output logic [DATA_W-1:0]       mem_wr_data,
    input  logic [DATA_W-1:0]       mem_rd_data
);

    localparam int WORDS = 2**ADDR_W;

    generate
        if (ACC_CYC < 1 || ACC_CYC > 15) begin : g_bad_acc_cyc
            $error("binary_ram_ctrl: ACC_CYC must be in 1..15");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [WORDS-1:0]    mem_cs_q, mem_cs_d;
    logic                mem_rd_wr_q, mem_rd_wr_d;
    logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                in_xfer;

    // Next-state and capture logic. Request fields are only taken on the
    // IDLE handshake, so they stay frozen for the whole transaction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(ACC_CYC - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                // Counter reaching zero marks the last select cycle; the
                // cells' read data is valid while select is still high.
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rd_data;
                    end
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output flops are loaded from the state being entered, so every strobe
    // is a clean register output aligned with its state. rd_wr and write
    // data use the freshly captured request on entry to SETUP.
    always_comb begin
        in_xfer       = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
        mem_rd_wr_d   = (in_xfer && we_d) ? MEM_WR : MEM_RD;
        mem_wr_data_d = (in_xfer && we_d) ? wdata_d : '0;
        rsp_valid_d   = (state_d == RESP);
        rsp_we_d      = (state_d == RESP) && we_q;
        rsp_rdata_d   = ((state_d == RESP) && !we_q) ? rdata_q : '0;
    end

    // Select is only raised while in ACCESS; addr_q is already stable by then.
    addr_onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en     (state_d == ACCESS),
        .addr   (addr_q),
        .onehot (mem_cs_d)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            mem_cs_q      <= '0;
            mem_rd_wr_q   <= MEM_RD;
            mem_wr_data_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_we_q      <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            mem_cs_q      <= mem_cs_d;
            mem_rd_wr_q   <= mem_rd_wr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_we_q      <= rsp_we_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign mem_cs      = mem_cs_q;
    assign mem_rd_wr   = mem_rd_wr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_we      = rsp_we_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_binary_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_binary_ram_ctrl
// Drives binary_ram_ctrl against a 16x4 SR-latch array model. Stimulus pushes
// the expected response (type, data, arrival cycle) computed from a plain
// word array; a monitor pops and compares whenever rsp_valid is seen, and a
// protocol watcher checks the memory strobe sequencing.
// -----------------------------------------------------------------------------
module tb_binary_ram_ctrl;

    parameter int ACC_CYC = 2;
    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int WORDS = 2**AW;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DW-1:0]     rsp_rdata;
    logic [WORDS-1:0]  mem_cs;
    logic              mem_rd_wr;
    logic [DW-1:0]     mem_wr_data;
    logic [DW-1:0]     mem_rd_data;

    logic [DW-1:0]     cells [WORDS];
    logic [DW-1:0]     ref_mem [WORDS];
    exp_t              sb_q [$];

    int                n_vectors = 0;
    int                n_miscompares = 0;
    int                cyc = 0;
    logic              rst_at_edge;

    logic              cur_we = 1'b0;
    logic [AW-1:0]     cur_addr = '0;
    logic [DW-1:0]     cur_wdata = '0;
    logic              check_gap = 1'b0;
    logic              have_last = 1'b0;
    int                last_t = 0;

    logic [WORDS-1:0]  prev_cs;
    logic              prev_rd_wr;
    logic [DW-1:0]     prev_wr_data;
    int                hi_cnt;

    binary_ram_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ACC_CYC (ACC_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_we      (rsp_we),
        .rsp_rdata   (rsp_rdata),
        .mem_cs      (mem_cs),
        .mem_rd_wr   (mem_rd_wr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and record of whether the last edge was a reset edge.
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // SR-latch cell array: a selected word takes the bit-lines while rd_wr is low.
    always @(posedge clk) begin
        for (int i = 0; i < WORDS; i++) begin
            if (mem_cs[i] && (mem_rd_wr == 1'b0)) begin
                cells[i] <= mem_wr_data;
            end
        end
    end

    // Gated read data, ORed across all words.
    always_comb begin
        mem_rd_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (mem_cs[i] && mem_rd_wr) begin
                mem_rd_data = mem_rd_data | cells[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Presents a request (call at a falling edge) and waits, bounded, for
    // acceptance. On acceptance the reference array is consulted/updated and
    // the expected response is queued. Returns at the falling edge after the
    // accepting edge with req_valid still high.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int waited;
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            if (check_gap && have_last) begin
                checkOutput("accept_gap", 32'(cyc - last_t), 32'(4 + ACC_CYC));
            end
            have_last = 1'b1;
            last_t    = cyc;
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            e.we  = we;
            e.cyc = cyc + 3 + ACC_CYC;
            if (we) begin
                ref_mem[addr] = wdata;
                e.rdata = '0;
            end else begin
                e.rdata = ref_mem[addr];
            end
            sb_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Idle with junk on the request fields; it must all be ignored.
    task automatic idleCycles(input int n);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    // Scoreboard monitor: compares each response against the queued
    // expectation, including its arrival cycle, and flags overdue ones.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                checkOutput("rsp_missing", 32'(cyc), 32'(sb_q[0].cyc));
                void'(sb_q.pop_front());
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("rsp_we", 32'(rsp_we), 32'(e.we));
                    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    // Strobe protocol watcher: one-hot select, select matching the accepted
    // request, rd_wr/data settled the cycle before select rises and still
    // held the cycle after it falls, select held for exactly ACC_CYC cycles,
    // and safe idle levels whenever the controller is ready.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            hi_cnt <= 0;
        end else begin
            checkOutput("cs_onehot", 32'($countones(mem_cs) <= 1), 32'd1);
            if (req_ready) begin
                checkOutput("idle_strobes", {11'd0, mem_cs, mem_rd_wr, mem_wr_data},
                            {11'd0, {WORDS{1'b0}}, 1'b1, {DW{1'b0}}});
            end
            if (mem_cs != '0) begin
                hi_cnt <= (prev_cs == '0) ? 1 : hi_cnt + 1;
            end
            if (prev_cs == '0 && mem_cs != '0) begin
                checkOutput("cs_word", 32'(mem_cs), 32'(WORDS'(1) << cur_addr));
                checkOutput("setup_rd_wr", 32'(prev_rd_wr), 32'(!cur_we));
                checkOutput("setup_data", 32'(prev_wr_data), 32'(cur_we ? cur_wdata : '0));
                checkOutput("access_rd_wr", 32'(mem_rd_wr), 32'(prev_rd_wr));
                checkOutput("access_data", 32'(mem_wr_data), 32'(prev_wr_data));
            end
            if (prev_cs != '0 && mem_cs != '0) begin
                checkOutput("cs_steady", 32'(mem_cs), 32'(prev_cs));
            end
            if (prev_cs != '0 && mem_cs == '0) begin
                checkOutput("cs_width", 32'(hi_cnt), 32'(ACC_CYC));
                checkOutput("hold_rd_wr", 32'(mem_rd_wr), 32'(prev_rd_wr));
                checkOutput("hold_data", 32'(mem_wr_data), 32'(prev_wr_data));
            end
        end
        prev_cs      <= mem_cs;
        prev_rd_wr   <= mem_rd_wr;
        prev_wr_data <= mem_wr_data;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2000000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        hi_cnt    = 0;
        for (int i = 0; i < WORDS; i++) begin
            cells[i]   = '0;
            ref_mem[i] = '0;
        end

        // Reset for two edges, then check reset levels and idle stability.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mem_cs", 32'(mem_cs), 32'd0);
        checkOutput("rst_rd_wr", 32'(mem_rd_wr), 32'd1);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_hold", {10'd0, mem_cs, mem_rd_wr, req_ready, rsp_valid, rsp_we},
                        {10'd0, {WORDS{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0});
        end

        // Directed write then read of word 5.
        $display("[TB] write/read word 5");
        applyStimulus(1'b1, 4'd5, 4'hA);
        idleCycles(0);
        applyStimulus(1'b0, 4'd5, 4'h0);
        idleCycles(1);

        // Fill every word with addr^3, then read all back.
        $display("[TB] fill and read back all words");
        for (int a = 0; a < WORDS; a++) begin
            applyStimulus(1'b1, AW'(a), DW'(a) ^ 4'h3);
            idleCycles($urandom_range(0, 2));
        end
        for (int a = 0; a < WORDS; a++) begin
            applyStimulus(1'b0, AW'(a), DW'($urandom));
            idleCycles($urandom_range(0, 2));
        end

        // req_valid held high, alternating write/read at words 0 and 15.
        $display("[TB] continuous valid, alternating requests");
        have_last = 1'b0;
        check_gap = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'd0,  (k % 2 == 0) ? 4'hF : 4'h0);
            applyStimulus(1'b0, 4'd0,  DW'($urandom));
            applyStimulus(1'b1, 4'd15, (k % 2 == 0) ? 4'h0 : 4'hF);
            applyStimulus(1'b0, 4'd15, DW'($urandom));
        end
        check_gap = 1'b0;
        idleCycles(2);

        // Reset during the write access window of word 3; its response is dropped.
        $display("[TB] reset mid-write");
        applyStimulus(1'b1, 4'd3, 4'h9);
        idleCycles((ACC_CYC >= 2) ? 2 : 1);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_mem_cs", 32'(mem_cs), 32'd0);
        checkOutput("midrst_rd_wr", 32'(mem_rd_wr), 32'd1);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        applyStimulus(1'b1, 4'd3, 4'h6);
        idleCycles(0);
        applyStimulus(1'b0, 4'd3, 4'h0);
        idleCycles(1);

        // Randomised mixed traffic.
        $display("[TB] random traffic");
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom), AW'($urandom), DW'($urandom));
            idleCycles($urandom_range(0, 3));
        end

        idleCycles(ACC_CYC + 8);
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
